// File: rtl/inst_encoder.sv
// Instruction encoder: legality check, 16-bit word packing, address tagging.
// Optional INSTENC_CANON_EN canonicalises operand bits of operand-free opcodes.
module inst_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opc,
  input  logic [3:0]        in_ra,
  input  logic [1:0]        in_mode,
  input  logic [3:0]        in_rb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instcode,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [7:0]        err_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]       code_q [DEPTH];
  logic [15:0]       code_d [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [ADDR_W-1:0] tag_d  [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full_q, full_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_pulse_q, err_pulse_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              legal;
  logic              no_operands;
  logic [15:0]       word;
  logic              accept;
  logic              push;
  logic              pop;

  // Opcode/mode legality map of the downstream decoder
  always_comb begin
    legal       = 1'b0;
    no_operands = 1'b0;
    case (in_opc)
      6'b001100, 6'b010100, 6'b011100,
      6'b000001, 6'b000010: legal = (in_mode != 2'b11);
      6'b000011: legal = (in_mode == 2'b01) || (in_mode == 2'b10);
      6'b000101, 6'b000110, 6'b001110: begin
        legal       = 1'b1;
        no_operands = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Pack fields into the decoder word
  always_comb begin
    word = {in_opc, in_ra, in_mode, in_rb};
`ifdef INSTENC_CANON_EN
    if (no_operands) word[9:0] = '0;
`else
    if (no_operands) word = {in_opc, in_ra, in_mode, in_rb};
`endif
  end

  assign in_ready = !full_q;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign pop      = out_valid && out_ready;

  // FIFO, address counter and error bookkeeping next state
  always_comb begin
    code_d      = code_q;
    tag_d       = tag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pc_d        = pc_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (push) begin
      code_d[wr_ptr_q] = word;
      tag_d[wr_ptr_q]  = pc_q;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      pc_d             = pc_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (accept && !legal) begin
      err_pulse_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    full_d = (cnt_d == CW'(DEPTH));
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        code_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      pc_q        <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      code_q      <= code_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      pc_q        <= pc_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid    = (cnt_q != '0);
  assign out_instcode = out_valid ? code_q[rd_ptr_q] : '0;
  assign out_addr     = out_valid ? tag_q[rd_ptr_q] : '0;
  assign err_pulse    = err_pulse_q;
  assign err_cnt      = err_cnt_q;

endmodule
